// File: rtl/sw_cond.sv
// Multi-channel push-button conditioner: synchroniser, counter debounce,
// press/release strobes and a hold-to-auto-repeat strobe per channel.
`timescale 1ns/1ps
module sw_cond #(
  parameter int NUM_SW         = 3,
  parameter int DB_CYCLES      = 500000,
  parameter int RPT_DLY_CYCLES = 25000000,
  parameter int RPT_PER_CYCLES = 5000000,
  parameter bit SW_ACT_LOW     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SW-1:0]     i_sw,
  input  logic [NUM_SW-1:0]     i_rpt_en,
  output logic [NUM_SW-1:0]     o_level,
  output logic [NUM_SW-1:0]     o_press,
  output logic [NUM_SW-1:0]     o_release,
  output logic [NUM_SW-1:0]     o_rpt,
  output logic [2*NUM_SW-1:0]   o_dbg_state
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_RPT      = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  localparam logic [31:0] DB_LAST  = 32'(DB_CYCLES - 1);
  localparam logic [31:0] DLY_LAST = 32'(RPT_DLY_CYCLES - 1);
  localparam logic [31:0] PER_LAST = 32'(RPT_PER_CYCLES - 1);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    logic        sync1_q, sync2_q;
    logic        pressed;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic        level_q, level_d;
    logic        rise, fall;
    logic        press_q, release_q, rpt_q, rpt_d;
    logic [1:0]  state_q, state_d;
    logic [31:0] rpt_cnt_q, rpt_cnt_d;

    // Synchronisers idle at the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= SW_ACT_LOW;
        sync2_q <= SW_ACT_LOW;
      end else begin
        sync1_q <= i_sw[g];
        sync2_q <= sync1_q;
      end
    end

    assign pressed = sync2_q ^ SW_ACT_LOW;

    always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      if (pressed == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 32'd1;
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Release wins over everything, including a repeat due on the same edge.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_d     = 1'b0;
      if (fall) begin
        state_d   = ST_IDLE;
        rpt_cnt_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            rpt_cnt_d = '0;
            if (rise) begin
              rpt_d   = 1'b1;
              state_d = ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!i_rpt_en[g]) begin
              state_d   = ST_WAIT_REL;
              rpt_cnt_d = '0;
            end else if (rpt_cnt_q == DLY_LAST) begin
              rpt_d     = 1'b1;
              state_d   = ST_RPT;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 32'd1;
            end
          end
          ST_RPT: begin
            if (!i_rpt_en[g]) begin
              state_d   = ST_WAIT_REL;
              rpt_cnt_d = '0;
            end else if (rpt_cnt_q == PER_LAST) begin
              rpt_d     = 1'b1;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 32'd1;
            end
          end
          ST_WAIT_REL: begin
            rpt_cnt_d = '0;
          end
          default: begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rpt_q     <= 1'b0;
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= rise;
        release_q <= fall;
        rpt_q     <= rpt_d;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign o_level[g]            = level_q;
    assign o_press[g]            = press_q;
    assign o_release[g]          = release_q;
    assign o_rpt[g]              = rpt_q;
    assign o_dbg_state[2*g +: 2] = state_q;
  end

endmodule

// File: tb/tb_sw_cond.sv
// Directed bench for sw_cond: vector table for press/bounce, hand-written
// sequences for auto-repeat, repeat disable, reset mid-hold and release collision.
`timescale 1ns/1ps
module tb_sw_cond;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic [2:0] rpt_en;
  logic [2:0] o_level, o_press, o_release, o_rpt;
  logic [5:0] o_dbg_state;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int p_edge;
  int n;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  typedef struct {
    logic [2:0] sw;
    logic [2:0] en;
    int         reps;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [2:0] rpt;
  } vec_t;

  vec_t tbl[$];

  sw_cond #(
    .NUM_SW(3), .DB_CYCLES(4), .RPT_DLY_CYCLES(20), .RPT_PER_CYCLES(8), .SW_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(sw), .i_rpt_en(rpt_en),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_rpt(o_rpt),
    .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] s, input logic [2:0] e, input int r,
                              input logic [2:0] l, input logic [2:0] p,
                              input logic [2:0] rl, input logic [2:0] rp);
    vec_t v;
    v.sw = s; v.en = e; v.reps = r; v.lvl = l; v.prs = p; v.rel = rl; v.rpt = rp;
    return v;
  endfunction

  // Ticks until the chosen strobe of channel ch fires; n = ticks taken, -1 on timeout.
  task automatic wait_pulse(input int ch, input bit rel, input int max, output int cnt);
    cnt = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if ((rel ? o_release[ch] : o_press[ch]) === 1'b1) begin
        cnt = k;
        break;
      end
    end
  endtask

  task automatic cmp_rpt(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, (i < got_q.size()) ? got_q[i] : 32'hffff_ffff, exp_q[i]);
  endtask

  initial begin
    rst_n  = 1'b0;
    sw     = 3'b111;
    rpt_en = 3'b000;
    #2;
    chk("reset_outputs", {o_level, o_press, o_release, o_rpt}, 12'h000);
    chk("reset_state", o_dbg_state, 6'h00);
    tick(); tick();
    chk("reset_hold_outputs", {o_level, o_press, o_release, o_rpt}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // clean press on ch0, then bounce on ch1
    tbl.push_back(mk(3'b111, 3'b000,  3, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b110, 3'b000,  5, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b110, 3'b000,  1, 3'b001, 3'b001, 3'b000, 3'b001));
    tbl.push_back(mk(3'b110, 3'b000, 94, 3'b001, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  5, 3'b001, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  1, 3'b000, 3'b000, 3'b001, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  4, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b101, 3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b101, 3'b000,  2, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b101, 3'b000,  3, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b101, 3'b000,  5, 3'b000, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b101, 3'b000,  1, 3'b010, 3'b010, 3'b000, 3'b010));
    tbl.push_back(mk(3'b101, 3'b000,  3, 3'b010, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  5, 3'b010, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  1, 3'b000, 3'b000, 3'b010, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000,  3, 3'b000, 3'b000, 3'b000, 3'b000));

    for (int i = 0; i < tbl.size(); i++) begin
      sw     = tbl[i].sw;
      rpt_en = tbl[i].en;
      for (int r = 0; r < tbl[i].reps; r++) begin
        tick();
        chk($sformatf("vec%0d", i), {o_level, o_press, o_release, o_rpt},
            {tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rpt});
      end
    end

    // auto-repeat on ch2
    rpt_en = 3'b100;
    sw[2]  = 1'b0;
    wait_pulse(2, 1'b0, 20, n);
    chk("rpt_press_latency", n, 6);
    p_edge = edge_n;
    got_q.delete();
    if (o_rpt[2] === 1'b1) got_q.push_back(0);
    for (int k = 1; k <= 59; k++) begin
      tick();
      if (o_rpt[2] === 1'b1) got_q.push_back(32'(edge_n - p_edge));
    end
    exp_q = '{32'd0, 32'd20, 32'd28, 32'd36, 32'd44, 32'd52};
    cmp_rpt("autorepeat");
    sw[2] = 1'b1;
    wait_pulse(2, 1'b1, 20, n);
    chk("rpt_release_latency", n, 6);
    chk("rpt_release_level", o_level[2], 1'b0);
    repeat (5) tick();
    chk("rpt_idle_state", o_dbg_state[5:4], 2'd0);

    // repeat disable on ch0
    rpt_en[0] = 1'b1;
    sw[0]     = 1'b0;
    wait_pulse(0, 1'b0, 20, n);
    chk("dis_press_latency", n, 6);
    p_edge = edge_n;
    got_q.delete();
    if (o_rpt[0] === 1'b1) got_q.push_back(0);
    for (int k = 1; k <= 70; k++) begin
      if (k == 24) rpt_en[0] = 1'b0;
      if (k == 30) rpt_en[0] = 1'b1;
      tick();
      if (o_rpt[0] === 1'b1) got_q.push_back(32'(edge_n - p_edge));
    end
    exp_q = '{32'd0, 32'd20};
    cmp_rpt("rpt_disable");
    chk("dis_wait_rel_state", o_dbg_state[1:0], 2'd3);
    sw[0] = 1'b1;
    wait_pulse(0, 1'b1, 20, n);
    chk("dis_release_latency", n, 6);
    repeat (3) tick();
    sw[0] = 1'b0;
    wait_pulse(0, 1'b0, 20, n);
    chk("dis_repress_latency", n, 6);
    p_edge = edge_n;
    got_q.delete();
    if (o_rpt[0] === 1'b1) got_q.push_back(0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (o_rpt[0] === 1'b1) got_q.push_back(32'(edge_n - p_edge));
    end
    exp_q = '{32'd0, 32'd20, 32'd28};
    cmp_rpt("rpt_restored");
    sw[0] = 1'b1;
    wait_pulse(0, 1'b1, 20, n);
    chk("restored_release_latency", n, 6);
    repeat (3) tick();

    // reset mid-hold on ch1
    sw[1] = 1'b0;
    wait_pulse(1, 1'b0, 20, n);
    chk("rst_press_latency", n, 6);
    p_edge = edge_n;
    repeat (10) tick();
    chk("rst_pre_level", o_level[1], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {o_level, o_press, o_release, o_rpt}, 12'h000);
    chk("rst_async_state", o_dbg_state, 6'h00);
    tick();
    chk("rst_no_release", {o_level, o_press, o_release, o_rpt}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(1, 1'b0, 20, n);
    chk("rst_fresh_press_latency", n, 6);
    chk("rst_fresh_level", o_level[1], 1'b1);
    sw[1] = 1'b1;
    wait_pulse(1, 1'b1, 20, n);
    chk("rst_release_latency", n, 6);
    repeat (3) tick();

    // release lands on the first repeat edge of ch2
    rpt_en[2] = 1'b1;
    sw[2]     = 1'b0;
    wait_pulse(2, 1'b0, 20, n);
    chk("col_press_latency", n, 6);
    p_edge = edge_n;
    for (int k = 1; k <= 19; k++) begin
      if (k == 15) sw[2] = 1'b1;
      tick();
    end
    chk("col_pre_state", o_dbg_state[5:4], 2'd1);
    chk("col_pre_level", o_level[2], 1'b1);
    tick();
    chk("col_edge_offset", edge_n - p_edge, 20);
    chk("col_release", o_release[2], 1'b1);
    chk("col_rpt_suppressed", o_rpt[2], 1'b0);
    chk("col_level", o_level[2], 1'b0);
    chk("col_idle_state", o_dbg_state[5:4], 2'd0);
    got_q.delete();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_rpt[2] === 1'b1) got_q.push_back(32'(edge_n - p_edge));
    end
    exp_q.delete();
    cmp_rpt("col_after");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
